// File: rtl/openhw_bmuctrl_pipe.sv
// openhw_bmuctrl_pipe
//   Decode-stage bit-manipulation decoder and the D->E pipeline register that
//   feeds openhw_bitmanipalu. BRegWriteD is exported combinationally from
//   Decode for the main controller and hazard unit.
//   Optional feature macro: OPENHW_BMU_ILLEGAL_EN
//     defined   -> IllegalBitmanipInstrD flags unsupported encodings inside the
//                  bitmanip funct7 groups (disabled subsets, W forms at XLEN=32)
//     undefined -> IllegalBitmanipInstrD is tied low
module openhw_bmuctrl_pipe #(
  parameter int   XLEN          = 32,
  parameter logic ZBA_SUPPORTED = 1'b1,
  parameter logic ZBB_SUPPORTED = 1'b1,
  parameter logic ZBC_SUPPORTED = 1'b1,
  parameter logic ZBS_SUPPORTED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [31:0] InstrD,
  output logic        BRegWriteD,
  output logic        IllegalBitmanipInstrD,
  output logic [1:0]  BSelectE,
  output logic [2:0]  ZBBSelectE,
  output logic [2:0]  BALUControlE,
  output logic        BW64E,
  output logic        BMUActiveE
);

  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;

  localparam logic [6:0] F7Clmul = 7'b0000101;
  localparam logic [6:0] F7Shadd = 7'b0010000;
  localparam logic [6:0] F7Zext  = 7'b0000100;
  localparam logic [6:0] F7Bclr  = 7'b0100100;
  localparam logic [6:0] F7Bset  = 7'b0010100;
  localparam logic [6:0] F7Binv  = 7'b0110100;
  localparam logic [6:0] F7Andn  = 7'b0100000;
  localparam logic [6:0] F7Rot   = 7'b0110000;

  localparam logic        Rv64    = (XLEN == 64);
  localparam logic [11:0] Rev8Imm = Rv64 ? 12'h6B8 : 12'h698;
  localparam logic [11:0] OrcbImm = 12'h287;

  // Which extension a matched encoding belongs to, so it can be gated by parameter
  typedef enum logic [2:0] {
    SubNone,
    SubZba,
    SubZbb,
    SubZbc,
    SubZbs
  } subset_t;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [5:0] w_funct6;
  logic [6:0] w_shf7;
  logic [4:0] w_rs2;
  logic [11:0] w_imm;
  logic        w_unusedFields;

  logic        w_match;
  subset_t     w_subset;
  logic        w_enabled;
  logic        w_legal;
  logic [1:0]  w_bSel;
  logic [2:0]  w_zbbSel;
  logic [2:0]  w_aluCtl;
  logic        w_w64;

  logic [1:0]  w_bSelD;
  logic [2:0]  w_zbbSelD;
  logic [2:0]  w_aluCtlD;
  logic        w_w64D;

  logic [1:0]  r_bSelE;
  logic [2:0]  r_zbbSelE;
  logic [2:0]  r_aluCtlE;
  logic        r_w64E;
  logic        r_activeE;

  assign w_opcode = InstrD[6:0];
  assign w_funct3 = InstrD[14:12];
  assign w_funct7 = InstrD[31:25];
  assign w_funct6 = InstrD[31:26];
  assign w_rs2    = InstrD[24:20];
  assign w_imm    = InstrD[31:20];

  // On RV64 the OP-IMM shift amount is 6 bits, so bit 25 belongs to shamt and
  // must not take part in the funct7 comparison of shift-immediate forms.
  assign w_shf7 = Rv64 ? {InstrD[31:26], 1'b0} : InstrD[31:25];

  // rd and rs1 never influence the control decode.
  assign w_unusedFields = ^{InstrD[19:15], InstrD[11:7]};

  // Raw decode: recognise each bitmanip encoding and pick its BMU controls
  always_comb begin
    w_match  = 1'b0;
    w_subset = SubNone;
    w_bSel   = 2'b00;
    w_zbbSel = 3'b000;
    w_aluCtl = 3'b000;
    w_w64    = 1'b0;
    case (w_opcode)
      OpcOp: begin
        if (w_funct7 == F7Clmul && (w_funct3 inside {3'b001, 3'b010, 3'b011})) begin
          w_match  = 1'b1;
          w_subset = SubZbc;
          w_bSel   = 2'b11;
        end else if (w_funct7 == F7Clmul && w_funct3[2]) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_bSel   = 2'b10;
          w_zbbSel = 3'b010;
        end else if (w_funct7 == F7Shadd && (w_funct3 inside {3'b010, 3'b100, 3'b110})) begin
          w_match  = 1'b1;
          w_subset = SubZba;
          w_bSel   = 2'b01;
          w_aluCtl = 3'b001;
        end else if ((w_funct7 == F7Bclr && (w_funct3 inside {3'b001, 3'b101})) ||
                     (w_funct7 == F7Bset && w_funct3 == 3'b001) ||
                     (w_funct7 == F7Binv && w_funct3 == 3'b001)) begin
          w_match  = 1'b1;
          w_subset = SubZbs;
          w_bSel   = 2'b01;
          w_aluCtl = 3'b010;
        end else if (w_funct7 == F7Andn && (w_funct3 inside {3'b111, 3'b110, 3'b100})) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_bSel   = 2'b10;
          w_zbbSel = 3'b111;
        end else if (!Rv64 && w_funct7 == F7Zext && w_funct3 == 3'b100 && w_rs2 == 5'd0) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_bSel   = 2'b10;
          w_zbbSel = 3'b001;
        end else if (w_funct7 == F7Rot && (w_funct3 inside {3'b001, 3'b101})) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_aluCtl = 3'b100;
        end
      end
      OpcOpImm: begin
        if ((w_shf7 == F7Bclr && (w_funct3 inside {3'b001, 3'b101})) ||
            (w_shf7 == F7Bset && w_funct3 == 3'b001) ||
            (w_shf7 == F7Binv && w_funct3 == 3'b001)) begin
          w_match  = 1'b1;
          w_subset = SubZbs;
          w_bSel   = 2'b01;
          w_aluCtl = 3'b010;
        end else if (w_funct7 == F7Rot && w_funct3 == 3'b001 &&
                     (w_rs2 inside {5'd0, 5'd1, 5'd2})) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_bSel   = 2'b10;
          w_zbbSel = 3'b000;
        end else if (w_funct7 == F7Rot && w_funct3 == 3'b001 &&
                     (w_rs2 inside {5'd4, 5'd5})) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_bSel   = 2'b10;
          w_zbbSel = 3'b001;
        end else if (w_funct3 == 3'b101 && (w_imm == Rev8Imm || w_imm == OrcbImm)) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_bSel   = 2'b10;
          w_zbbSel = 3'b011;
        end else if (w_shf7 == F7Rot && w_funct3 == 3'b101) begin
          w_match  = 1'b1;
          w_subset = SubZbb;
          w_aluCtl = 3'b100;
        end
      end
      OpcOp32: begin
        if (Rv64) begin
          if (w_funct7 == F7Shadd && (w_funct3 inside {3'b010, 3'b100, 3'b110})) begin
            w_match  = 1'b1;
            w_subset = SubZba;
            w_bSel   = 2'b01;
            w_aluCtl = 3'b001;
            w_w64    = 1'b1;
          end else if (w_funct7 == F7Zext && w_funct3 == 3'b000) begin
            w_match  = 1'b1;
            w_subset = SubZba;
            w_bSel   = 2'b01;
            w_w64    = 1'b1;
          end else if (w_funct7 == F7Zext && w_funct3 == 3'b100 && w_rs2 == 5'd0) begin
            // zext.h lives in OP-32 on RV64 but operates on the full register
            w_match  = 1'b1;
            w_subset = SubZbb;
            w_bSel   = 2'b10;
            w_zbbSel = 3'b001;
          end else if (w_funct7 == F7Rot && (w_funct3 inside {3'b001, 3'b101})) begin
            w_match  = 1'b1;
            w_subset = SubZbb;
            w_aluCtl = 3'b100;
            w_w64    = 1'b1;
          end
        end
      end
      OpcOpImm32: begin
        if (Rv64) begin
          if (w_funct6 == 6'b000010 && w_funct3 == 3'b001) begin
            w_match  = 1'b1;
            w_subset = SubZba;
            w_bSel   = 2'b01;
            w_w64    = 1'b1;
          end else if (w_funct7 == F7Rot && w_funct3 == 3'b001 &&
                       (w_rs2 inside {5'd0, 5'd1, 5'd2})) begin
            w_match  = 1'b1;
            w_subset = SubZbb;
            w_bSel   = 2'b10;
            w_zbbSel = 3'b000;
            w_w64    = 1'b1;
          end else if (w_funct7 == F7Rot && w_funct3 == 3'b101) begin
            w_match  = 1'b1;
            w_subset = SubZbb;
            w_aluCtl = 3'b100;
            w_w64    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Gate the matched encoding by whether its extension is built in
  always_comb begin
    case (w_subset)
      SubZba:  w_enabled = ZBA_SUPPORTED;
      SubZbb:  w_enabled = ZBB_SUPPORTED;
      SubZbc:  w_enabled = ZBC_SUPPORTED;
      SubZbs:  w_enabled = ZBS_SUPPORTED;
      default: w_enabled = 1'b0;
    endcase
  end

  assign w_legal    = w_match & w_enabled;
  assign BRegWriteD = w_legal;

  assign w_bSelD   = w_legal ? w_bSel   : 2'b00;
  assign w_zbbSelD = w_legal ? w_zbbSel : 3'b000;
  assign w_aluCtlD = w_legal ? w_aluCtl : 3'b000;
  assign w_w64D    = w_legal & w_w64;

`ifdef OPENHW_BMU_ILLEGAL_EN
  logic w_inSpace;

  function automatic logic isBmuGroup(input logic [6:0] f7);
    isBmuGroup = f7 inside {F7Clmul, F7Shadd, F7Zext, F7Bclr, F7Bset, F7Binv, F7Andn, F7Rot};
  endfunction

  // Bitmanip encoding space: the bitmanip funct7 groups, minus sub/sra/srai
  // (and their W forms) which share funct7 0100000 with andn/orn/xnor
  always_comb begin
    w_inSpace = 1'b0;
    case (w_opcode)
      OpcOp, OpcOp32: begin
        w_inSpace = isBmuGroup(w_funct7) &&
                    !(w_funct7 == F7Andn && (w_funct3 inside {3'b000, 3'b101}));
      end
      OpcOpImm: begin
        if (w_funct3 inside {3'b001, 3'b101}) begin
          w_inSpace = isBmuGroup(w_shf7) && !(w_shf7 == F7Andn && w_funct3 == 3'b101);
        end
      end
      OpcOpImm32: begin
        if (w_funct3 inside {3'b001, 3'b101}) begin
          w_inSpace = (isBmuGroup(w_funct7) && !(w_funct7 == F7Andn && w_funct3 == 3'b101)) ||
                      (w_funct6 == 6'b000010 && w_funct3 == 3'b001);
        end
      end
      default: ;
    endcase
  end

  assign IllegalBitmanipInstrD = w_inSpace & ~w_legal;
`else
  assign IllegalBitmanipInstrD = 1'b0;
`endif

  // D->E register: reset and flush bubble (flush beats stall), stall holds
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_bSelE   <= 2'b00;
      r_zbbSelE <= 3'b000;
      r_aluCtlE <= 3'b000;
      r_w64E    <= 1'b0;
      r_activeE <= 1'b0;
    end else if (!StallE) begin
      r_bSelE   <= w_bSelD;
      r_zbbSelE <= w_zbbSelD;
      r_aluCtlE <= w_aluCtlD;
      r_w64E    <= w_w64D;
      r_activeE <= w_legal;
    end
  end

  assign BSelectE     = r_bSelE;
  assign ZBBSelectE   = r_zbbSelE;
  assign BALUControlE = r_aluCtlE;
  assign BW64E        = r_w64E;
  assign BMUActiveE   = r_activeE;

endmodule

// File: tb/tb_openhw_bmuctrl_pipe.sv
// tb_openhw_bmuctrl_pipe
//   Directed bench for openhw_bmuctrl_pipe. Three instances share the inputs:
//   the default RV32 build, an RV64 build and an RV32 build without Zbc.
//   Expected illegal-flag values follow OPENHW_BMU_ILLEGAL_EN.
module tb_openhw_bmuctrl_pipe;

  localparam logic [31:0] InstrClmul   = 32'h0A3110B3;
  localparam logic [31:0] InstrSh2add  = 32'h2000C033;
  localparam logic [31:0] InstrAndn    = 32'h403170B3;
  localparam logic [31:0] InstrRor     = 32'h603150B3;
  localparam logic [31:0] InstrMin     = 32'h0A3140B3;
  localparam logic [31:0] InstrAddUw   = 32'h083100BB;
  localparam logic [31:0] InstrBseti   = 32'h28511093;
  localparam logic [31:0] InstrRev8    = 32'h69815093;
  localparam logic [31:0] InstrCpop    = 32'h60211093;
  localparam logic [31:0] InstrCpopBad = 32'h60311093;
  localparam logic [31:0] InstrSub     = 32'h403100B3;

`ifdef OPENHW_BMU_ILLEGAL_EN
  localparam logic ExpIllegal = 1'b1;
`else
  localparam logic ExpIllegal = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stallE;
  logic        flushE;
  logic [31:0] instrD;

  logic        bRegWriteD,   bRegWriteD64,   bRegWriteDNz;
  logic        illegalD,     illegalD64,     illegalDNz;
  logic [1:0]  bSelectE,     bSelectE64,     bSelectENz;
  logic [2:0]  zbbSelectE,   zbbSelectE64,   zbbSelectENz;
  logic [2:0]  bAluCtlE,     bAluCtlE64,     bAluCtlENz;
  logic        bW64E,        bW64E64,        bW64ENz;
  logic        bmuActiveE,   bmuActiveE64,   bmuActiveENz;

  logic [9:0]  eVec;
  logic [9:0]  eVec64;

  int checkCount;
  int errorCount;

  assign eVec   = {bSelectE,   zbbSelectE,   bAluCtlE,   bW64E,   bmuActiveE};
  assign eVec64 = {bSelectE64, zbbSelectE64, bAluCtlE64, bW64E64, bmuActiveE64};

  openhw_bmuctrl_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .StallE(stallE), .FlushE(flushE), .InstrD(instrD),
    .BRegWriteD(bRegWriteD), .IllegalBitmanipInstrD(illegalD),
    .BSelectE(bSelectE), .ZBBSelectE(zbbSelectE), .BALUControlE(bAluCtlE),
    .BW64E(bW64E), .BMUActiveE(bmuActiveE)
  );

  openhw_bmuctrl_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .StallE(stallE), .FlushE(flushE), .InstrD(instrD),
    .BRegWriteD(bRegWriteD64), .IllegalBitmanipInstrD(illegalD64),
    .BSelectE(bSelectE64), .ZBBSelectE(zbbSelectE64), .BALUControlE(bAluCtlE64),
    .BW64E(bW64E64), .BMUActiveE(bmuActiveE64)
  );

  openhw_bmuctrl_pipe #(.XLEN(32), .ZBC_SUPPORTED(1'b0)) dutNoZbc (
    .clk(clk), .reset(reset), .StallE(stallE), .FlushE(flushE), .InstrD(instrD),
    .BRegWriteD(bRegWriteDNz), .IllegalBitmanipInstrD(illegalDNz),
    .BSelectE(bSelectENz), .ZBBSelectE(zbbSelectENz), .BALUControlE(bAluCtlENz),
    .BW64E(bW64ENz), .BMUActiveE(bmuActiveENz)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] instr, input logic stall,
                               input logic flush, input logic rst);
    instrD = instr;
    stallE = stall;
    flushE = flush;
    reset  = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence; E-vector layout is {BSel[1:0], ZBB[2:0], {Rot,Mask,Pre}, W64, Active}
  initial begin
    checkCount = 0;
    errorCount = 0;

    applyStimulus(InstrClmul, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset_e_zero", {22'd0, eVec}, 32'd0);
    checkOutput("reset_d_follows", {31'd0, bRegWriteD}, 32'd1);

    applyStimulus(InstrClmul, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("clmul_e", {22'd0, eVec}, {22'd0, 10'b11_000_000_0_1});

    applyStimulus(InstrSh2add, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("sh2add_rv64_e", {22'd0, eVec64}, {22'd0, 10'b01_000_001_0_1});

    applyStimulus(InstrAndn, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("andn_e", {22'd0, eVec}, {22'd0, 10'b10_111_000_0_1});

    applyStimulus(InstrRor, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold_e", {22'd0, eVec}, {22'd0, 10'b10_111_000_0_1});
    end
    applyStimulus(InstrRor, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ror_e", {22'd0, eVec}, {22'd0, 10'b00_000_100_0_1});

    applyStimulus(InstrMin, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("flush_over_stall", {22'd0, eVec}, 32'd0);
    applyStimulus(InstrMin, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("min_e", {22'd0, eVec}, {22'd0, 10'b10_010_000_0_1});

    applyStimulus(InstrClmul, 1'b0, 1'b0, 1'b0);
    checkOutput("nozbc_clmul_wr", {31'd0, bRegWriteDNz}, 32'd0);
    checkOutput("nozbc_clmul_ill", {31'd0, illegalDNz}, {31'd0, ExpIllegal});
    checkOutput("zbc_clmul_wr", {31'd0, bRegWriteD}, 32'd1);
    checkOutput("zbc_clmul_ill", {31'd0, illegalD}, 32'd0);

    applyStimulus(InstrAddUw, 1'b0, 1'b0, 1'b0);
    checkOutput("adduw_rv32_wr", {31'd0, bRegWriteD}, 32'd0);
    checkOutput("adduw_rv32_ill", {31'd0, illegalD}, {31'd0, ExpIllegal});
    tick();
    checkOutput("adduw_rv32_active", {31'd0, bmuActiveE}, 32'd0);
    checkOutput("adduw_rv64_e", {22'd0, eVec64}, {22'd0, 10'b01_000_000_1_1});

    applyStimulus(InstrBseti, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bseti_e", {22'd0, eVec}, {22'd0, 10'b01_000_010_0_1});
    applyStimulus(InstrBseti, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("midreset_e_zero", {22'd0, eVec}, 32'd0);
    checkOutput("midreset_d", {31'd0, bRegWriteD}, 32'd1);

    applyStimulus(InstrRev8, 1'b0, 1'b0, 1'b0);
    checkOutput("rev8_rv32_wr", {31'd0, bRegWriteD}, 32'd1);
    checkOutput("rev8_imm_on_rv64", {31'd0, bRegWriteD64}, 32'd0);
    tick();
    checkOutput("rev8_e", {22'd0, eVec}, {22'd0, 10'b10_011_000_0_1});

    applyStimulus(InstrCpop, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("cpop_e", {22'd0, eVec}, {22'd0, 10'b10_000_000_0_1});

    applyStimulus(InstrCpopBad, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt_rs2_3_wr", {31'd0, bRegWriteD}, 32'd0);

    applyStimulus(InstrSub, 1'b0, 1'b0, 1'b0);
    checkOutput("sub_wr", {31'd0, bRegWriteD}, 32'd0);
    checkOutput("sub_ill", {31'd0, illegalD}, 32'd0);
    tick();
    checkOutput("sub_e", {22'd0, eVec}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
